palette_dac: RTL and testbench

- Programmable colour-lookup DAC for the video output path.
- Replaces the fixed 16-entry CGA colour map.
- A per-pixel index goes through a pixel mask and a register-file palette (2^IDX_W entries, 3×CW bits each) to registered R/G/B outputs that drive the analog resistor DAC.
- A small host register interface programs and reads back the palette, one colour component per access, with auto-incrementing indices.

---
 rtl/palette_dac_if.sv | 12 +
 rtl/palette_dac.sv | 162 ++++++++++++++++
 tb/tb_palette_dac.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/palette_dac_if.sv
// Host register bus for palette_dac: single-cycle strobed accesses, registered read data.
interface palette_dac_if;
  logic       sel;
  logic       wr;
  logic       rd;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output sel, output wr, output rd, output addr, output din, input dout);
  modport slave  (input sel, input wr, input rd, input addr, input din, output dout);
endinterface

// File: rtl/palette_dac.sv
// Programmable colour-lookup DAC: masked pixel index -> palette -> registered R/G/B,
// with an auto-incrementing host interface for programming and reading back entries.
module palette_dac #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned CW        = 6,
  parameter bit          RESET_CGA = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] video,
  input  logic             blank,
  palette_dac_if.slave     bus,
  output logic [CW-1:0]    red,
  output logic [CW-1:0]    green,
  output logic [CW-1:0]    blue
);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TW    = 3 * CW;
  localparam int unsigned L3    = (1 << CW) - 1;
  localparam int unsigned L1    = L3 / 3;
  localparam int unsigned L2    = (2 * L3) / 3;

  typedef enum logic [1:0] {A_WIDX = 2'd0, A_DATA = 2'd1, A_RIDX = 2'd2, A_MASK = 2'd3} addr_e;
  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_e;

  // Reset colour for entry i: CGA map on entries 0..15, black elsewhere.
  function automatic logic [TW-1:0] cga_entry(input int unsigned i);
    logic [CW-1:0] lo, hi, r, g, b;
    lo = (i >= 8) ? CW'(L1) : '0;
    hi = (i >= 8) ? CW'(L3) : CW'(L2);
    r  = i[2] ? hi : lo;
    g  = i[1] ? hi : lo;
    b  = i[0] ? hi : lo;
    if (i == 6) g = CW'(L1);
    if (!RESET_CGA || i >= 16) return '0;
    return {r, g, b};
  endfunction

  addr_e            addr;
  logic [CW-1:0]    comp;
  logic             unused_din;
  phase_e           wphase, wphase_nxt, rphase, rphase_nxt;
  logic [IDX_W-1:0] widx, widx_nxt, ridx, ridx_nxt, mask, mask_nxt;
  logic [CW-1:0]    stage_r, stage_r_nxt, stage_g, stage_g_nxt;
  logic [7:0]       dout_nxt;
  logic             commit_c, reload_c;
  logic [TW-1:0]    hold;
  logic [TW-1:0]    pal [DEPTH];
  logic [IDX_W-1:0] idx_d;
  logic             blank_d;

  assign addr       = addr_e'(bus.addr);
  assign comp       = bus.din[CW-1:0];
  assign unused_din = ^bus.din;

  // Bus decode: write sequencer, read sequencer and register updates.
  always_comb begin
    wphase_nxt  = wphase;
    rphase_nxt  = rphase;
    widx_nxt    = widx;
    ridx_nxt    = ridx;
    mask_nxt    = mask;
    stage_r_nxt = stage_r;
    stage_g_nxt = stage_g;
    dout_nxt    = bus.dout;
    commit_c    = 1'b0;
    reload_c    = 1'b0;
    if (bus.sel && bus.wr) begin
      case (addr)
        A_WIDX: begin
          widx_nxt   = bus.din[IDX_W-1:0];
          wphase_nxt = PH_R;
        end
        A_DATA: begin
          case (wphase)
            PH_R: begin stage_r_nxt = comp; wphase_nxt = PH_G; end
            PH_G: begin stage_g_nxt = comp; wphase_nxt = PH_B; end
            default: begin
              commit_c   = 1'b1;
              widx_nxt   = widx + IDX_W'(1);
              wphase_nxt = PH_R;
            end
          endcase
        end
        A_RIDX: begin
          ridx_nxt   = bus.din[IDX_W-1:0];
          rphase_nxt = PH_R;
          reload_c   = 1'b1;
        end
        default: mask_nxt = bus.din[IDX_W-1:0];
      endcase
    end else if (bus.sel && bus.rd) begin
      case (addr)
        A_WIDX: dout_nxt = 8'(widx);
        A_DATA: begin
          case (rphase)
            PH_R: begin dout_nxt = 8'(hold[TW-1 -: CW]);   rphase_nxt = PH_G; end
            PH_G: begin dout_nxt = 8'(hold[2*CW-1 -: CW]); rphase_nxt = PH_B; end
            default: begin
              dout_nxt   = 8'(hold[CW-1:0]);
              rphase_nxt = PH_R;
              ridx_nxt   = ridx + IDX_W'(1);
              reload_c   = 1'b1;
            end
          endcase
        end
        A_RIDX:  dout_nxt = 8'(ridx);
        default: dout_nxt = 8'(mask);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wphase   <= PH_R;
      rphase   <= PH_R;
      widx     <= '0;
      ridx     <= '0;
      mask     <= '1;
      stage_r  <= '0;
      stage_g  <= '0;
      bus.dout <= '0;
      hold     <= cga_entry(0);
    end else begin
      wphase   <= wphase_nxt;
      rphase   <= rphase_nxt;
      widx     <= widx_nxt;
      ridx     <= ridx_nxt;
      mask     <= mask_nxt;
      stage_r  <= stage_r_nxt;
      stage_g  <= stage_g_nxt;
      bus.dout <= dout_nxt;
      if (reload_c) hold <= pal[ridx_nxt];
    end
  end

  // Palette entries; a whole triplet lands in one clock on the B write.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [TW-1:0] entry_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   entry_q <= cga_entry(e);
      else if (commit_c && widx == IDX_W'(e))         entry_q <= {stage_r, stage_g, comp};
    end
    assign pal[e] = entry_q;
  end

  // Two-stage video path: mask/blank capture, then lookup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_d   <= '0;
      blank_d <= 1'b1;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      idx_d   <= video & mask;
      blank_d <= blank;
      if (blank_d) {red, green, blue} <= '0;
      else         {red, green, blue} <= pal[idx_d];
    end
  end
endmodule

// File: tb/tb_palette_dac.sv
// Randomised and directed bench for palette_dac against a queue/array reference model.
module tb_palette_dac;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CW    = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [IDX_W-1:0] video = '0;
  logic             blank = 1'b0;
  logic [CW-1:0]    red, green, blue;

  palette_dac_if bus();

  palette_dac #(.IDX_W(IDX_W), .CW(CW), .RESET_CGA(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .video(video), .blank(blank),
    .bus(bus), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cga [16] = '{'h000000, 'h00002A, 'h002A00, 'h002A2A, 'h2A0000, 'h2A002A, 'h2A1500, 'h2A2A2A,
                   'h151515, 'h15153F, 'h153F15, 'h153F3F, 'h3F1515, 'h3F153F, 'h3F3F15, 'h3F3F3F};
  int pal_r [16];
  int pal_g [16];
  int pal_b [16];
  int staged [$];
  int widx_m, ridx_m, mask_m, reads_done, hold_r, hold_g, hold_b, dout_m;
  int p_idx, exp_rgb;
  bit p_blank;

  function automatic int pack_rgb(input int r, input int g, input int b);
    return (r << 12) | (g << 6) | b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      pal_r[i] = (cga[i] >> 16) & 'hFF;
      pal_g[i] = (cga[i] >> 8) & 'hFF;
      pal_b[i] = cga[i] & 'hFF;
    end
    staged.delete();
    widx_m = 0; ridx_m = 0; mask_m = 15; reads_done = 0;
    hold_r = pal_r[0]; hold_g = pal_g[0]; hold_b = pal_b[0];
    dout_m = 0; p_idx = 0; p_blank = 1'b1; exp_rgb = 0;
  endfunction

  // One clock edge of the reference: video lookup sees the palette before this edge's commit.
  function automatic void model_edge(input bit s, input bit w, input bit r, input int a, input int d,
                                     input int v, input bit bl);
    exp_rgb = p_blank ? 0 : pack_rgb(pal_r[p_idx], pal_g[p_idx], pal_b[p_idx]);
    p_idx   = v & mask_m;
    p_blank = bl;
    if (s && w) begin
      case (a)
        0: begin widx_m = d % 16; staged.delete(); end
        1: begin
          staged.push_back(d % 64);
          if (staged.size() == 3) begin
            pal_r[widx_m] = staged[0]; pal_g[widx_m] = staged[1]; pal_b[widx_m] = staged[2];
            widx_m = (widx_m + 1) % 16;
            staged.delete();
          end
        end
        2: begin
          ridx_m = d % 16; reads_done = 0;
          hold_r = pal_r[ridx_m]; hold_g = pal_g[ridx_m]; hold_b = pal_b[ridx_m];
        end
        default: mask_m = d % 16;
      endcase
    end else if (s && r) begin
      case (a)
        0: dout_m = widx_m;
        1: begin
          dout_m = (reads_done == 0) ? hold_r : (reads_done == 1) ? hold_g : hold_b;
          reads_done++;
          if (reads_done == 3) begin
            reads_done = 0;
            ridx_m = (ridx_m + 1) % 16;
            hold_r = pal_r[ridx_m]; hold_g = pal_g[ridx_m]; hold_b = pal_b[ridx_m];
          end
        end
        2: dout_m = ridx_m;
        default: dout_m = mask_m;
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int want);
    checks++;
    assert (got === 32'(want)) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input bit s, input bit w, input bit r, input int a, input int d,
                      input int v, input bit bl);
    bus.sel  = s;
    bus.wr   = w;
    bus.rd   = r;
    bus.addr = 2'(a);
    bus.din  = 8'(d);
    video    = IDX_W'(v);
    blank    = bl;
    @(posedge clk);
    model_edge(s, w, r, a, d, v, bl);
    #1;
    chk("rgb", 32'({red, green, blue}), exp_rgb);
    chk("dout", 32'(bus.dout), dout_m);
  endtask

  task automatic idle(input int v, input bit bl);
    step(1'b0, 1'b0, 1'b0, 0, 0, v, bl);
  endtask

  task automatic do_reset();
    bus.sel = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.din = '0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_rgb", 32'({red, green, blue}), 0);
    chk("reset_dout", 32'(bus.dout), 0);
    #2 reset_n = 1'b1;
  endtask

  int rd_exp [6] = '{'h15, 'h15, 'h3F, 'h15, 'h3F, 'h15};

  initial begin
    bus.sel = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.din = '0;
    model_reset();
    #12;
    chk("reset_rgb0", 32'({red, green, blue}), 0);
    #4 reset_n = 1'b1;

    // CGA table sweep
    for (int v = 0; v < 16; v++) idle(v, 1'b0);
    idle(15, 1'b0);
    chk("cga_f", 32'({red, green, blue}), pack_rgb('h3F, 'h3F, 'h3F));
    idle(0, 1'b0);

    // Atomic commit while entry 5 is on screen
    step(1, 1, 0, 0, 5, 5, 0);
    step(1, 1, 0, 1, 'h3F, 5, 0);
    chk("pre_commit_g", 32'({red, green, blue}), pack_rgb('h2A, 0, 'h2A));
    step(1, 1, 0, 1, 'h00, 5, 0);
    step(1, 1, 0, 1, 'h11, 5, 0);
    chk("at_commit", 32'({red, green, blue}), pack_rgb('h2A, 0, 'h2A));
    idle(5, 0);
    idle(5, 0);
    chk("post_commit", 32'({red, green, blue}), pack_rgb('h3F, 0, 'h11));

    // Write index wrap at top of palette
    step(1, 1, 0, 0, 15, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 8 + i, 0, 0);
    step(1, 0, 1, 0, 0, 15, 0);
    chk("widx_wrap", 32'(bus.dout), 1);
    idle(15, 0);
    chk("entry15", 32'({red, green, blue}), pack_rgb(8, 9, 10));

    // Read-back with auto-increment across entries 9 and 10
    step(1, 1, 0, 2, 9, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 1, 0, 0, 0);
      chk("rd_seq", 32'(bus.dout), rd_exp[i]);
    end
    step(1, 0, 1, 2, 0, 0, 0);
    chk("ridx_after", 32'(bus.dout), 11);

    // Pixel mask and blanking
    step(1, 1, 0, 3, 3, 14, 0);
    idle(14, 0);
    idle(14, 0);
    chk("mask_rgb", 32'({red, green, blue}), pack_rgb(0, 'h2A, 0));
    idle(14, 1);
    idle(14, 0);
    chk("blank_rgb", 32'({red, green, blue}), 0);
    step(1, 1, 0, 3, 15, 0, 0);

    // Reset in the middle of a write triplet
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 'h01, 0, 0);
    step(1, 1, 0, 1, 'h02, 0, 0);
    do_reset();
    step(1, 1, 0, 1, 'h0A, 0, 0);
    step(1, 1, 0, 1, 'h0B, 0, 0);
    step(1, 1, 0, 1, 'h0C, 0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("reset_seq", 32'({red, green, blue}), pack_rgb('h0A, 'h0B, 'h0C));

    // Random traffic, including simultaneous write/read strobes
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      if (n == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
